// File: rtl/id_pkg.sv
// Shared types and constants for the decode-stage issue sequencer.
package id_pkg;

    localparam int REG_W   = 5;
    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        SIGNAL  = 2'd2,
        RELEASE = 2'd3
    } id_state_e;

    // Fixed-width part of the ID/EXE register; the payload travels beside it.
    typedef struct packed {
        logic               valid;
        logic [INSTR_W-1:0] instr;
        logic [INSTR_W-1:0] pc;
        logic [REG_W-1:0]   write_reg;
        logic               reg_write;
        logic               mem_read;
    } id_ctrl_t;

    // A bubble is an all-zero ID/EXE entry.
    localparam id_ctrl_t BUBBLE = '0;

endpackage

// File: rtl/id_hazard_unit.sv
// Load-use compare between the instruction in ID/EXE and the one being decoded.
module id_hazard_unit
    import id_pkg::*;
(
    input  logic             valid,
    input  logic             mem_read,
    input  logic [REG_W-1:0] write_reg,
    input  logic [REG_W-1:0] reg_a,
    input  logic [REG_W-1:0] reg_b,
    input  logic             uses_b,
    output logic             hazard
);

    // Register 0 is never a real producer, so it is excluded up front.
    assign hazard = valid && mem_read && (write_reg != '0) &&
                    ((reg_a == write_reg) || (uses_b && (reg_b == write_reg)));

endmodule

// File: rtl/id_issue_ctrl.sv
// Decode-stage issue sequencer: owns the ID/EXE register, drains the pipe
// around serialising instructions and raises SYS for the simulator.
// Build option: ID_LOAD_USE_INTERLOCK_EN adds the load-use interlock.
//
// state   | meaning
// --------+--------------------------------------------------------
// RUN     | normal issue; bubbles on no input or load-use hazard
// DRAIN   | bubbles after a serialiser while drain_cnt counts down
// SIGNAL  | one bubble cycle that loads SYS from the latched notify
// RELEASE | SYS cleared, one bubble, back to RUN
module id_issue_ctrl
    import id_pkg::*;
#(
    parameter int PAYLOAD_W        = 96,
    parameter int DRAIN_CYCLES     = 3,
    parameter int LOAD_USE_BUBBLES = 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INSTR_W-1:0]   Instr_IN,
    input  logic [INSTR_W-1:0]   Instr_PC_IN,
    input  logic [PAYLOAD_W-1:0] Payload_IN,
    input  logic [REG_W-1:0]     RegA_IN,
    input  logic [REG_W-1:0]     RegB_IN,
    input  logic                 UsesB_IN,
    input  logic [REG_W-1:0]     WriteReg_IN,
    input  logic                 RegWrite_IN,
    input  logic                 MemRead_IN,
    input  logic                 Serialize_IN,
    input  logic                 NotifySim_IN,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [INSTR_W-1:0]   Instr_OUT,
    output logic [INSTR_W-1:0]   Instr_PC_OUT,
    output logic [PAYLOAD_W-1:0] Payload_OUT,
    output logic [REG_W-1:0]     WriteReg_OUT,
    output logic                 RegWrite_OUT,
    output logic                 MemRead_OUT,
    output logic                 SYS,
    output logic                 WANT_FREEZE
);

    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15) begin : g_bad_drain
        $error("DRAIN_CYCLES must be in 1..15");
    end
    if (LOAD_USE_BUBBLES < 1 || LOAD_USE_BUBBLES > 3) begin : g_bad_lub
        $error("LOAD_USE_BUBBLES must be in 1..3");
    end

    id_state_e              state, state_n;
    logic [3:0]             drain_cnt, drain_n;
    logic                   notify_q, notify_n;
    logic                   sys_q, sys_n;
    id_ctrl_t               ctrl_q, ctrl_n;
    logic [PAYLOAD_W-1:0]   payload_q, payload_n;
    logic                   hazard;
    logic                   hz_busy;
    logic                   accept;

`ifdef ID_LOAD_USE_INTERLOCK_EN
    logic       hazard_raw;
    logic [1:0] hz_cnt;

    id_hazard_unit u_hazard (
        .valid     (ctrl_q.valid),
        .mem_read  (ctrl_q.mem_read),
        .write_reg (ctrl_q.write_reg),
        .reg_a     (RegA_IN),
        .reg_b     (RegB_IN),
        .uses_b    (UsesB_IN),
        .hazard    (hazard_raw)
    );

    assign hazard  = hazard_raw && (state == RUN);
    assign hz_busy = (hz_cnt != 2'd0);

    // Extra interlock bubbles beyond the first one that the hazard itself inserts.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hz_cnt <= 2'd0;
        end else if (out_ready && (state == RUN)) begin
            if (hazard) begin
                hz_cnt <= 2'(LOAD_USE_BUBBLES - 1);
            end else if (hz_busy) begin
                hz_cnt <= hz_cnt - 2'd1;
            end
        end
    end
`else
    // EXE forwarding covers load-use; source operands are not needed here.
    logic unused_hz;
    assign unused_hz = ^{RegA_IN, RegB_IN, UsesB_IN};
    assign hazard    = 1'b0;
    assign hz_busy   = 1'b0;
`endif

    assign in_ready    = RESET && out_ready && (state == RUN) && !hazard && !hz_busy;
    assign accept      = in_valid && in_ready;
    assign WANT_FREEZE = RESET && (((state == RUN) && in_valid && Serialize_IN) ||
                                   (state == DRAIN) || (state == SIGNAL));

    // Next-state and next ID/EXE contents, assuming the stage advances.
    always_comb begin
        state_n   = state;
        drain_n   = drain_cnt;
        notify_n  = notify_q;
        sys_n     = 1'b0;
        ctrl_n    = BUBBLE;
        payload_n = '0;
        unique case (state)
            RUN: begin
                if (accept) begin
                    ctrl_n.valid     = 1'b1;
                    ctrl_n.instr     = Instr_IN;
                    ctrl_n.pc        = Instr_PC_IN;
                    ctrl_n.write_reg = WriteReg_IN;
                    ctrl_n.reg_write = RegWrite_IN && (WriteReg_IN != '0);
                    ctrl_n.mem_read  = MemRead_IN;
                    payload_n        = Payload_IN;
                    if (Serialize_IN) begin
                        // Still travels to MEM for the cache flush, but writes nothing.
                        ctrl_n.reg_write = 1'b0;
                        ctrl_n.mem_read  = 1'b0;
                        notify_n         = NotifySim_IN;
                        drain_n          = 4'(DRAIN_CYCLES);
                        state_n          = DRAIN;
                    end
                end
            end
            DRAIN: begin
                drain_n = drain_cnt - 4'd1;
                if (drain_cnt <= 4'd1) begin
                    drain_n = 4'd0;
                    state_n = SIGNAL;
                end
            end
            SIGNAL: begin
                sys_n   = notify_q;
                state_n = RELEASE;
            end
            RELEASE: begin
                notify_n = 1'b0;
                state_n  = RUN;
            end
            default: state_n = RUN;
        endcase
    end

    // ID/EXE register, FSM and drain counter; everything holds while EXE stalls.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= RUN;
            drain_cnt <= 4'd0;
            notify_q  <= 1'b0;
            sys_q     <= 1'b0;
            ctrl_q    <= BUBBLE;
            payload_q <= '0;
        end else if (out_ready) begin
            state     <= state_n;
            drain_cnt <= drain_n;
            notify_q  <= notify_n;
            sys_q     <= sys_n;
            ctrl_q    <= ctrl_n;
            payload_q <= payload_n;
        end
    end

    assign out_valid    = ctrl_q.valid;
    assign Instr_OUT    = ctrl_q.instr;
    assign Instr_PC_OUT = ctrl_q.pc;
    assign WriteReg_OUT = ctrl_q.write_reg;
    assign RegWrite_OUT = ctrl_q.reg_write;
    assign MemRead_OUT  = ctrl_q.mem_read;
    assign Payload_OUT  = payload_q;
    assign SYS          = sys_q;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed bench for id_issue_ctrl with default parameters
// (DRAIN_CYCLES=3, LOAD_USE_BUBBLES=1); follows ID_LOAD_USE_INTERLOCK_EN.
module tb_id_issue_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Instr_IN, Instr_PC_IN;
    logic [95:0] Payload_IN;
    logic [4:0]  RegA_IN, RegB_IN, WriteReg_IN;
    logic        UsesB_IN, RegWrite_IN, MemRead_IN, Serialize_IN, NotifySim_IN;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] Instr_OUT, Instr_PC_OUT;
    logic [95:0] Payload_OUT;
    logic [4:0]  WriteReg_OUT;
    logic        RegWrite_OUT, MemRead_OUT, SYS, WANT_FREEZE;

    int tests = 0;
    int fails = 0;

`ifdef ID_LOAD_USE_INTERLOCK_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    localparam logic [31:0] I_SYSCALL = 32'h0000_000C;
    localparam logic [31:0] I_LL      = 32'hC128_0000;
    localparam logic [31:0] I_LW8     = 32'h8D28_0000;
    localparam logic [31:0] I_ADD     = 32'h010A_4820;
    localparam logic [31:0] I_LW0     = 32'h8C00_0000;
    localparam logic [31:0] I_ADD0    = 32'h000A_4820;

    id_issue_ctrl dut (
        .CLK(CLK), .RESET(RESET),
        .in_valid(in_valid), .in_ready(in_ready),
        .Instr_IN(Instr_IN), .Instr_PC_IN(Instr_PC_IN), .Payload_IN(Payload_IN),
        .RegA_IN(RegA_IN), .RegB_IN(RegB_IN), .UsesB_IN(UsesB_IN),
        .WriteReg_IN(WriteReg_IN), .RegWrite_IN(RegWrite_IN), .MemRead_IN(MemRead_IN),
        .Serialize_IN(Serialize_IN), .NotifySim_IN(NotifySim_IN),
        .out_ready(out_ready), .out_valid(out_valid),
        .Instr_OUT(Instr_OUT), .Instr_PC_OUT(Instr_PC_OUT), .Payload_OUT(Payload_OUT),
        .WriteReg_OUT(WriteReg_OUT), .RegWrite_OUT(RegWrite_OUT), .MemRead_OUT(MemRead_OUT),
        .SYS(SYS), .WANT_FREEZE(WANT_FREEZE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [4:0] ra, input logic [4:0] rb, input logic ub,
                         input logic [4:0] wr, input logic rw, input logic mr,
                         input logic ser, input logic ns);
        in_valid     = v;
        Instr_IN     = ins;
        Instr_PC_IN  = pc;
        Payload_IN   = {ins, pc, ~ins};
        RegA_IN      = ra;
        RegB_IN      = rb;
        UsesB_IN     = ub;
        WriteReg_IN  = wr;
        RegWrite_IN  = rw;
        MemRead_IN   = mr;
        Serialize_IN = ser;
        NotifySim_IN = ns;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Full serialiser sequence with an add waiting behind it.
    task automatic serial_seq(input string nm, input logic [31:0] ins, input logic ns);
        drive(1'b1, ins, 32'h400, 5'd0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b1, ns);
        #1;
        check({nm, " freeze_pre"}, WANT_FREEZE, 1'b1);
        check({nm, " ready_pre"}, in_ready, 1'b1);
        tick();
        check({nm, " c1 instr"}, Instr_OUT, ins);
        check({nm, " c1 valid"}, out_valid, 1'b1);
        check({nm, " c1 regwrite"}, RegWrite_OUT, 1'b0);
        check({nm, " c1 sys"}, SYS, 1'b0);
        drive(1'b1, I_ADD, 32'h404, 5'd8, 5'd10, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check({nm, " c1 ready"}, in_ready, 1'b0);
        check({nm, " c1 freeze"}, WANT_FREEZE, 1'b1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check($sformatf("%s c%0d bubble_valid", nm, i), out_valid, 1'b0);
            check($sformatf("%s c%0d bubble_instr", nm, i), Instr_OUT, 32'h0);
            check($sformatf("%s c%0d sys", nm, i), SYS, 1'b0);
            check($sformatf("%s c%0d freeze", nm, i), WANT_FREEZE, 1'b1);
        end
        tick();
        check({nm, " c5 sys"}, SYS, ns);
        check({nm, " c5 freeze"}, WANT_FREEZE, 1'b0);
        check({nm, " c5 ready"}, in_ready, 1'b0);
        tick();
        check({nm, " c6 sys"}, SYS, 1'b0);
        check({nm, " c6 freeze"}, WANT_FREEZE, 1'b0);
        check({nm, " c6 ready"}, in_ready, 1'b1);
        tick();
        check({nm, " c7 instr"}, Instr_OUT, I_ADD);
        check({nm, " c7 pc"}, Instr_PC_OUT, 32'h404);
        check({nm, " c7 payload"}, Payload_OUT, {I_ADD, 32'h404, ~I_ADD});
        check({nm, " c7 regwrite"}, RegWrite_OUT, 1'b1);
        check({nm, " c7 wreg"}, WriteReg_OUT, 5'd9);
        idle();
        tick();
    endtask

    initial begin
        // Reset state
        RESET     = 1'b0;
        out_ready = 1'b1;
        idle();
        #3;
        check("rst valid", out_valid, 1'b0);
        check("rst instr", Instr_OUT, 32'h0);
        check("rst payload", Payload_OUT, 96'h0);
        check("rst sys", SYS, 1'b0);
        check("rst ready", in_ready, 1'b0);
        tick();
        RESET = 1'b1;
        #1;
        check("post_rst ready", in_ready, 1'b1);

        // Syscall with notify, then LL without
        serial_seq("syscall", I_SYSCALL, 1'b1);
        serial_seq("ll", I_LL, 1'b0);

        // Load-use: lw $8 then add $9,$8,$10
        drive(1'b1, I_LW8, 32'h500, 5'd9, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("lw memread", MemRead_OUT, 1'b1);
        check("lw regwrite", RegWrite_OUT, 1'b1);
        check("lw wreg", WriteReg_OUT, 5'd8);
        drive(1'b1, I_ADD, 32'h504, 5'd8, 5'd10, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("lu ready", in_ready, !HZ);
        tick();
        if (HZ) begin
            check("lu bubble", out_valid, 1'b0);
            check("lu bubble instr", Instr_OUT, 32'h0);
            check("lu ready2", in_ready, 1'b1);
            tick();
        end
        check("lu add issued", Instr_OUT, I_ADD);
        check("lu add pc", Instr_PC_OUT, 32'h504);
        idle();
        tick();

        // EXE stall of 4 cycles during DRAIN
        drive(1'b1, I_SYSCALL, 32'h600, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        check("stall c1 instr", Instr_OUT, I_SYSCALL);
        idle();
        out_ready = 1'b0;
        #1;
        check("stall ready", in_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("stall hold%0d instr", i), Instr_OUT, I_SYSCALL);
            check($sformatf("stall hold%0d valid", i), out_valid, 1'b1);
            check($sformatf("stall hold%0d sys", i), SYS, 1'b0);
            check($sformatf("stall hold%0d freeze", i), WANT_FREEZE, 1'b1);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall resume%0d sys", i), SYS, 1'b0);
        end
        tick();
        check("stall sys", SYS, 1'b1);
        tick();
        check("stall sys_clear", SYS, 1'b0);
        tick();

        // Reset while drain_cnt=2
        drive(1'b1, I_SYSCALL, 32'h700, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        idle();
        tick();
        RESET = 1'b0;
        #1;
        check("mid_rst valid", out_valid, 1'b0);
        check("mid_rst instr", Instr_OUT, 32'h0);
        check("mid_rst pc", Instr_PC_OUT, 32'h0);
        check("mid_rst freeze", WANT_FREEZE, 1'b0);
        #2;
        RESET = 1'b1;
        #1;
        check("mid_rst run", in_ready, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("mid_rst sys%0d", i), SYS, 1'b0);
            check($sformatf("mid_rst freeze%0d", i), WANT_FREEZE, 1'b0);
        end

        // lw $0 then a use of $0
        drive(1'b1, I_LW0, 32'h800, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("lw0 regwrite", RegWrite_OUT, 1'b0);
        check("lw0 memread", MemRead_OUT, 1'b1);
        check("lw0 valid", out_valid, 1'b1);
        drive(1'b1, I_ADD0, 32'h804, 5'd0, 5'd10, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("r0 ready", in_ready, 1'b1);
        tick();
        check("r0 add issued", Instr_OUT, I_ADD0);
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/id_issue_ctrl.md
Name: id_issue_ctrl

Overview:
Parametrised second-generation sequencer for the decode stage, sitting between the Decoder/RegFile outputs and the ID/EXE pipeline register.
- Owns the ID/EXE register itself, with a valid/ready handshake to fetch (upstream) and EXE (downstream).
- Generalises the fixed syscall bubble counter into a serialisation FSM with parametrised drain depth.
- Adds a load-use interlock with parametrised bubble count.
- Payload width is generic, so operands and control bits from the decoder travel as one opaque bundle.

Parameters:
PAYLOAD_W, 96, width of the opaque decoded bundle (OperandA, OperandB, ALU control, shift amount, etc.).
DRAIN_CYCLES, 3, bubbles emitted after a serialising instruction before SYS is raised; legal range 1..15.
LOAD_USE_BUBBLES, 1, bubbles inserted on a load-use hazard; legal range 1..3.

Ports:
CLK  in  1  clock; all state on the rising edge.
RESET  in  1  asynchronous, active-low reset.
in_valid  in  1  fetch/decode presents an instruction.
in_ready  out  1  instruction accepted this cycle when in_valid && in_ready.
Instr_IN  in  32  raw instruction word.
Instr_PC_IN  in  32  PC of the instruction.
Payload_IN  in  PAYLOAD_W  decoded bundle.
RegA_IN  in  5  source register A.
RegB_IN  in  5  source register B.
UsesB_IN  in  1  RegB_IN is a true source.
WriteReg_IN  in  5  destination register.
RegWrite_IN  in  1  instruction writes WriteReg_IN.
MemRead_IN  in  1  instruction is a load.
Serialize_IN  in  1  syscall, LL or SC; pipeline must drain.
NotifySim_IN  in  1  raise SYS for this serialiser (0 for LL/SC).
out_ready  in  1  EXE accepts; when low, all outputs hold.
out_valid  out  1  ID/EXE register holds a real instruction.
Instr_OUT  out  32  issued instruction, 0 on bubble.
Instr_PC_OUT  out  32  PC of the issued instruction.
Payload_OUT  out  PAYLOAD_W  issued bundle, 0 on bubble.
WriteReg_OUT  out  5  destination register.
RegWrite_OUT  out  1  write enable; forced 0 when WriteReg is 0, on bubbles, and for serialisers.
MemRead_OUT  out  1  load flag; 0 on bubble.
SYS  out  1  one-cycle request to the simulator.
WANT_FREEZE  out  1  fetch must hold its PC.

Behaviour:
- Reset (RESET low, asynchronous): all outputs 0, FSM in RUN, counters 0. Reset mid-drain aborts the sequence; no SYS is produced afterwards.
- The ID/EXE register updates only on cycles where out_ready=1. When out_ready=0, every output, the state and the counters hold, and in_ready=0.
- Latency: one cycle from acceptance to the outputs.
- FSM states: RUN, DRAIN, SIGNAL, RELEASE.
- RUN: in_ready = out_ready && !hazard.
  - Normal acceptance: load all outputs from the inputs, out_valid=1.
  - Acceptance with Serialize_IN=1: issue the instruction with RegWrite_OUT=0 and MemRead_OUT=0 (it still reaches MEM for the cache flush), latch NotifySim_IN, load drain_cnt=DRAIN_CYCLES, go to DRAIN.
  - No acceptance: issue a bubble.
- DRAIN: in_ready=0; issue a bubble each advancing cycle and decrement drain_cnt. When drain_cnt reaches 0, go to SIGNAL.
- SIGNAL: one cycle; SYS <= latched NotifySim; bubble; go to RELEASE.
- RELEASE: SYS <= 0; bubble; go to RUN. A back-to-back serialiser is accepted on the following RUN cycle.
- WANT_FREEZE = (RUN && in_valid && Serialize_IN) || DRAIN || SIGNAL. It is combinational and deasserts in RELEASE.
- Hazard (RUN only): out_valid && MemRead_OUT && WriteReg_OUT!=0 && ((RegA_IN==WriteReg_OUT) || (UsesB_IN && RegB_IN==WriteReg_OUT)).
  - On hazard: insert a bubble, load hz_cnt=LOAD_USE_BUBBLES-1.
  - While hz_cnt is nonzero: in_ready=0, bubbles are issued, hz_cnt decrements.
- A hazard and a serialiser in the same cycle: the hazard wins; the serialiser is accepted after the hazard clears.
- Register 0 as a destination never triggers a hazard.

Optional Feature:
- Macro: ID_LOAD_USE_INTERLOCK_EN.
- Defined: hazard detection and hz_cnt are present, as described above.
- Undefined: hazard is tied to 0 and LOAD_USE_BUBBLES is ignored. EXE forwarding then covers load-use, and hz_cnt is not synthesised.

Decomposition:
- Shared package id_pkg holds:
  - the FSM state enum (RUN=0, DRAIN=1, SIGNAL=2, RELEASE=3);
  - REG_W=5 and INSTR_W=32;
  - the bubble constant (all-zero output).
- One sub-module, id_hazard_unit: purely combinational hazard compare, instantiated only under ID_LOAD_USE_INTERLOCK_EN.

Test Plan:
- Reset mid-DRAIN (assert RESET while drain_cnt=2) -> all outputs 0 immediately; FSM in RUN; no SYS on the following cycles.
- Syscall 0x0000000C, NotifySim=1, DRAIN_CYCLES=3 -> cycle 1: Instr_OUT=0xC, RegWrite_OUT=0. Cycles 2-4: bubbles. Cycle 5: SYS=1. Cycle 6: SYS=0 and WANT_FREEZE=0. Cycle 7: next instruction accepted.
- LL serialiser with NotifySim=0 -> same timing; SYS stays 0 throughout.
- lw $8 followed by add $9,$8,$10, interlock enabled, LOAD_USE_BUBBLES=1 -> exactly one bubble, then the add issues. Macro undefined -> the add issues the cycle after the load.
- out_ready held low for 4 cycles during DRAIN -> outputs and drain_cnt frozen; SYS is delayed by exactly 4 cycles.
- lw $0 followed by a use of $0 -> no bubble; RegWrite_OUT=0 for the load.
